// File: rtl/div_if.sv
// Operand/result bundle between the execute-stage ALU and the iterative divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/div_iter.sv
// Signed restoring shift-subtract divider: one quotient bit per clock on magnitudes,
// sign fix-up in a final cycle, fixed latency independent of operand values.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic  clock,
    input  logic  reset,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   r_prem;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_zero;
    logic             r_exc_pend;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exc;
    logic             r_rdy;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Magnitudes are formed at WIDTH+1 bits so |most-negative| = 2^(WIDTH-1) survives intact.
    assign w_a_ext  = {bus.data_operandA[WIDTH-1], bus.data_operandA};
    assign w_b_ext  = {bus.data_operandB[WIDTH-1], bus.data_operandB};
    assign w_a_mag  = bus.data_operandA[WIDTH-1] ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag  = bus.data_operandB[WIDTH-1] ? (~w_b_ext + 1'b1) : w_b_ext;
    assign w_b_zero = (bus.data_operandB == '0);
    assign w_ovf    = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data_operandB == '1);

    // The single shared subtractor: trial subtract of the divisor from the shifted remainder.
    assign w_shift  = {r_prem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, r_div};
    assign w_fit    = ~w_trial[WIDTH+1];

    assign w_q_fix  = r_qneg ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix  = r_rneg ? (~r_prem[WIDTH-1:0] + 1'b1) : r_prem[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_prem      <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_zero      <= 1'b0;
            r_exc_pend  <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exc       <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (bus.ctrl_DIV) begin
                // A start in any state (including mid-run) discards the current operation.
                r_state    <= S_RUN;
                r_count    <= '0;
                r_quo      <= w_a_mag[WIDTH-1:0];
                r_div      <= w_b_mag[WIDTH-1:0];
                r_prem     <= '0;
                r_qneg     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                r_rneg     <= bus.data_operandA[WIDTH-1];
                r_zero     <= w_b_zero;
                r_exc_pend <= w_b_zero | w_ovf;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_prem  <= w_fit ? w_trial[WIDTH:0] : w_shift;
                        r_quo   <= {r_quo[WIDTH-2:0], w_fit};
                        r_count <= r_count + 1'b1;
                        if (r_count == CW'(WIDTH-1)) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // With a zero divisor the remainder register ends holding |A|,
                        // and the overflow case naturally yields 2^(WIDTH-1) with rem 0.
                        r_result    <= r_zero ? '0 : w_q_fix;
                        r_remainder <= w_r_fix;
                        r_exc       <= r_exc_pend;
                        r_rdy       <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_remainder = r_remainder;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = (r_state != S_IDLE) | r_rdy;
endmodule

// File: tb/tb_div_iter.sv
// Directed and random checks of the iterative divider: latency, signs, exceptions, restart, reset.
module tb_div_iter;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    div_if #(.WIDTH(WIDTH)) bus ();

    div_iter #(.WIDTH(WIDTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one division, wait for RDY (bounded), report observed values and pulse shape.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [31:0] rem,
                           output logic exc, output int lat,
                           output logic busy_at_rdy, output logic rdy_after);
        @(negedge clk);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        @(negedge clk);
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.data_resultRDY) break;
        end
        res         = bus.data_result;
        rem         = bus.data_remainder;
        exc         = bus.data_exception;
        busy_at_rdy = bus.busy;
        @(negedge clk);
        rdy_after   = bus.data_resultRDY;
    endtask

    task automatic test_reset();
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b, want all 0",
                     bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        rst = 1'b0;
        $display("reset: outputs after 2-cycle reset res=%h busy=%b", bus.data_result, bus.busy);

        // Start, re-pulse mid-run, then reset: busy must drop and no RDY may follow.
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd500; bus.data_operandB = 32'd5;
        @(negedge clk); bus.ctrl_DIV = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_in_run: got %b want 1", bus.busy);
        end
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd600;
        @(negedge clk); bus.ctrl_DIV = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_after_reset: got %b want 0", bus.busy);
        end
        begin
            int rdy_seen;
            rdy_seen = 0;
            for (int i = 0; i < 45; i++) begin
                @(negedge clk);
                if (bus.data_resultRDY) rdy_seen++;
            end
            n_checks++;
            if (rdy_seen !== 0) begin
                n_errors++;
                $display("FAIL no_rdy_after_reset: got %0d pulses want 0", rdy_seen);
            end
            $display("reset: mid-run reset, busy=%b, rdy pulses=%0d", bus.busy, rdy_seen);
        end

        // ctrl_DIV and reset on the same edge: stays idle.
        @(negedge clk);
        rst = 1'b1; bus.ctrl_DIV = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.ctrl_DIV = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wins_start: busy got %b want 0", bus.busy);
        end
    endtask

    // Directed table: basic, sign combinations, exceptions and most-negative dividend.
    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic [31:0] tq [7];
        logic [31:0] tr [7];
        logic        te [7];
        logic [31:0] res, rem;
        logic        exc, busy_r, rdy_n;
        int          lat;
        ta[0] = 32'd100;       tb[0] = 32'd7;          tq[0] = 32'd14;         tr[0] = 32'd2;          te[0] = 1'b0;
        ta[1] = -32'sd100;     tb[1] = 32'd7;          tq[1] = -32'sd14;       tr[1] = -32'sd2;        te[1] = 1'b0;
        ta[2] = 32'd100;       tb[2] = -32'sd7;        tq[2] = -32'sd14;       tr[2] = 32'd2;          te[2] = 1'b0;
        ta[3] = -32'sd100;     tb[3] = -32'sd7;        tq[3] = 32'd14;         tr[3] = -32'sd2;        te[3] = 1'b0;
        ta[4] = 32'd55;        tb[4] = 32'd0;          tq[4] = 32'd0;          tr[4] = 32'd55;         te[4] = 1'b1;
        ta[5] = 32'h8000_0000; tb[5] = 32'hFFFF_FFFF;  tq[5] = 32'h8000_0000;  tr[5] = 32'd0;          te[5] = 1'b1;
        ta[6] = 32'h8000_0000; tb[6] = 32'd1;          tq[6] = 32'h8000_0000;  tr[6] = 32'd0;          te[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_div(ta[i], tb[i], res, rem, exc, lat, busy_r, rdy_n);
            $display("directed %0d: A=%h B=%h -> q=%h r=%h exc=%b lat=%0d", i, ta[i], tb[i], res, rem, exc, lat);
            n_checks++;
            if (lat !== LAT) begin
                n_errors++;
                $display("FAIL latency[%0d]: got %0d want %0d", i, lat, LAT);
            end
            n_checks++;
            if (res !== tq[i]) begin
                n_errors++;
                $display("FAIL quotient[%0d]: got %h want %h", i, res, tq[i]);
            end
            n_checks++;
            if (rem !== tr[i]) begin
                n_errors++;
                $display("FAIL remainder[%0d]: got %h want %h", i, rem, tr[i]);
            end
            n_checks++;
            if (exc !== te[i]) begin
                n_errors++;
                $display("FAIL exception[%0d]: got %b want %b", i, exc, te[i]);
            end
            n_checks++;
            if (busy_r !== 1'b1 || rdy_n !== 1'b0) begin
                n_errors++;
                $display("FAIL rdy_pulse[%0d]: busy_at_rdy=%b rdy_next=%b want 1/0", i, busy_r, rdy_n);
            end
        end
        // Results hold after the RDY pulse.
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.data_result !== 32'h8000_0000 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_after_rdy: res=%h busy=%b want 80000000/0", bus.data_result, bus.busy);
        end
    endtask

    task automatic test_restart();
        int rdy_cnt, lat2;
        logic [31:0] res, rem;
        @(negedge clk);
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd3;
        @(posedge clk);
        @(negedge clk); bus.ctrl_DIV = 1'b0;
        repeat (9) @(negedge clk);
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd2;
        @(posedge clk);
        @(negedge clk); bus.ctrl_DIV = 1'b0;
        rdy_cnt = 0; lat2 = 0; res = '0; rem = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.data_resultRDY) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    lat2 = i; res = bus.data_result; rem = bus.data_remainder;
                end
            end
        end
        $display("restart: rdy pulses=%0d lat=%0d q=%0d r=%0d", rdy_cnt, lat2, res, rem);
        n_checks++;
        if (rdy_cnt !== 1) begin
            n_errors++;
            $display("FAIL restart_rdy_count: got %0d want 1", rdy_cnt);
        end
        n_checks++;
        if (lat2 !== LAT) begin
            n_errors++;
            $display("FAIL restart_latency: got %0d want %0d", lat2, LAT);
        end
        n_checks++;
        if (res !== 32'd4 || rem !== 32'd1) begin
            n_errors++;
            $display("FAIL restart_result: got q=%0d r=%0d want q=4 r=1", res, rem);
        end
    endtask

    task automatic test_random();
        logic [31:0] res, rem;
        logic        exc, busy_r, rdy_n;
        int          lat;
        int signed   a, b, eq, er;
        longint      chk, abs_r, abs_b;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            case (n % 3)
                0:       b = $urandom;
                1:       b = int'($urandom_range(0, 2000)) - 1000;
                default: b = int'($urandom_range(0, 16)) - 8;
            endcase
            if (b == 0) b = 3;
            if (a == 32'sh8000_0000 && b == -1) b = -2;
            eq = a / b;
            er = a % b;
            run_div(a, b, res, rem, exc, lat, busy_r, rdy_n);
            $display("random %0d: A=%0d B=%0d -> q=%0d r=%0d lat=%0d", n, a, b, $signed(res), $signed(rem), lat);
            n_checks++;
            if (res !== eq || rem !== er || exc !== 1'b0 || lat !== LAT) begin
                n_errors++;
                $display("FAIL random[%0d]: got q=%0d r=%0d exc=%b lat=%0d want q=%0d r=%0d exc=0 lat=%0d",
                         n, $signed(res), $signed(rem), exc, lat, eq, er, LAT);
            end
            chk   = longint'($signed(res)) * longint'(b) + longint'($signed(rem));
            abs_r = ($signed(rem) < 0) ? -longint'($signed(rem)) : longint'($signed(rem));
            abs_b = (b < 0) ? -longint'(b) : longint'(b);
            n_checks++;
            if (chk !== longint'(a) || abs_r >= abs_b) begin
                n_errors++;
                $display("FAIL identity[%0d]: q*B+r=%0d want %0d, |r|=%0d |B|=%0d", n, chk, a, abs_r, abs_b);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        test_reset();
        test_directed();
        test_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
